// File: rtl/s2mm_packet_arbiter_if.sv
// AXI4-Stream bundle carrying arbitrated packets into the MCDMA S2MM port.
interface s2mm_packet_arbiter_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEST_WIDTH = 4
) ();
    logic [DATA_WIDTH-1:0] tdata;
    logic [DEST_WIDTH-1:0] tdest;
    logic                  tlast;
    logic                  tvalid;
    logic                  tready;

    modport master (
        output tdata,
        output tdest,
        output tlast,
        output tvalid,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tdest,
        input  tlast,
        input  tvalid,
        output tready
    );
endinterface

// File: rtl/s2mm_packet_arbiter.sv
// Round-robin packet arbiter: drains one whole packet at a time from one of
// NUM_FIFOS first-word-fall-through FIFOs onto a single AXI stream, tagging
// every beat with the source index on tdest.
module s2mm_packet_arbiter #(
    parameter int unsigned AXIS_DATA_WIDTH = 32,
    parameter int unsigned FIFO_DATA_WIDTH = 32,
    parameter int unsigned AXIS_DEST_WIDTH = 4,
    parameter int unsigned NUM_FIFOS       = 2,
    parameter int unsigned PKT_LEN_WIDTH   = 16
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 enable,
    input  logic [NUM_FIFOS*PKT_LEN_WIDTH-1:0]   pkt_len,
    input  logic [NUM_FIFOS-1:0]                 fifo_empty,
    input  logic [NUM_FIFOS*FIFO_DATA_WIDTH-1:0] fifo_data,
    output logic [NUM_FIFOS-1:0]                 fifo_rden,
    s2mm_packet_arbiter_if.master                DST_AXIS,
    output logic                                 busy,
    output logic [AXIS_DEST_WIDTH-1:0]           grant_id
);

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    state_t                     state_q, state_d;
    logic [AXIS_DEST_WIDTH-1:0] last_q, last_d;
    logic [AXIS_DEST_WIDTH-1:0] grant_q, grant_d;
    logic [PKT_LEN_WIDTH-1:0]   len_q, len_d;
    logic [PKT_LEN_WIDTH-1:0]   cnt_q, cnt_d;
    logic [AXIS_DATA_WIDTH-1:0] tdata_q, tdata_d;
    logic [AXIS_DEST_WIDTH-1:0] tdest_q, tdest_d;
    logic                       tlast_q, tlast_d;
    logic                       tvalid_q, tvalid_d;

    logic [NUM_FIFOS-1:0]       req;
    logic                       req_any;
    logic [AXIS_DEST_WIDTH-1:0] pick;
    logic [PKT_LEN_WIDTH-1:0]   pick_len;
    logic                       sel_empty;
    logic [FIFO_DATA_WIDTH-1:0] sel_data;
    logic                       load;
    logic                       last_beat;

    // Per-source request: data available, non-zero length, arbitration enabled.
    always_comb begin
        req = '0;
        for (int unsigned i = 0; i < NUM_FIFOS; i++) begin
            req[i] = enable && !fifo_empty[i] &&
                     (pkt_len[i*PKT_LEN_WIDTH +: PKT_LEN_WIDTH] != '0);
        end
    end

    // Round-robin pick: first requester after the last served source, wrapping.
    always_comb begin
        int unsigned idx;
        req_any  = 1'b0;
        pick     = '0;
        pick_len = '0;
        idx      = 0;
        for (int unsigned k = 1; k <= NUM_FIFOS; k++) begin
            idx = (32'(last_q) + k) % NUM_FIFOS;
            for (int unsigned i = 0; i < NUM_FIFOS; i++) begin
                if (!req_any && (i == idx) && req[i]) begin
                    req_any  = 1'b1;
                    pick     = AXIS_DEST_WIDTH'(i);
                    pick_len = pkt_len[i*PKT_LEN_WIDTH +: PKT_LEN_WIDTH];
                end
            end
        end
    end

    // Mux out the granted FIFO's status and head word.
    always_comb begin
        sel_empty = 1'b1;
        sel_data  = '0;
        for (int unsigned i = 0; i < NUM_FIFOS; i++) begin
            if (grant_q == AXIS_DEST_WIDTH'(i)) begin
                sel_empty = fifo_empty[i];
                sel_data  = fifo_data[i*FIFO_DATA_WIDTH +: FIFO_DATA_WIDTH];
            end
        end
    end

    assign load      = (state_q == XFER) && !sel_empty && (!tvalid_q || DST_AXIS.tready);
    assign last_beat = (cnt_q == (len_q - PKT_LEN_WIDTH'(1)));

    // Pop strobe follows the load decision so the FIFO advances in the same cycle.
    always_comb begin
        fifo_rden = '0;
        for (int unsigned i = 0; i < NUM_FIFOS; i++) begin
            fifo_rden[i] = load && (grant_q == AXIS_DEST_WIDTH'(i));
        end
    end

    // Next-state, grant bookkeeping and output register update.
    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        grant_d  = grant_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        tdata_d  = tdata_q;
        tdest_d  = tdest_q;
        tlast_d  = tlast_q;
        tvalid_d = tvalid_q;

        // An accepted beat leaves the register; a load below may refill it in the same cycle.
        if (tvalid_q && DST_AXIS.tready) begin
            tvalid_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (req_any) begin
                    grant_d = pick;
                    len_d   = pick_len;
                    cnt_d   = '0;
                    state_d = XFER;
                end
            end
            XFER: begin
                if (load) begin
                    tdata_d                      = '0;
                    tdata_d[FIFO_DATA_WIDTH-1:0] = sel_data;
                    tdest_d                      = grant_q;
                    tlast_d                      = last_beat;
                    tvalid_d                     = 1'b1;
                    cnt_d                        = cnt_q + PKT_LEN_WIDTH'(1);
                    if (last_beat) begin
                        last_d  = grant_q;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset drops any held beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            last_q   <= AXIS_DEST_WIDTH'(NUM_FIFOS - 1);
            grant_q  <= '0;
            len_q    <= '0;
            cnt_q    <= '0;
            tdata_q  <= '0;
            tdest_q  <= '0;
            tlast_q  <= 1'b0;
            tvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            grant_q  <= grant_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            tdata_q  <= tdata_d;
            tdest_q  <= tdest_d;
            tlast_q  <= tlast_d;
            tvalid_q <= tvalid_d;
        end
    end

    assign DST_AXIS.tdata  = tdata_q;
    assign DST_AXIS.tdest  = tdest_q;
    assign DST_AXIS.tlast  = tlast_q;
    assign DST_AXIS.tvalid = tvalid_q;
    assign busy            = (state_q == XFER) || tvalid_q;
    assign grant_id        = grant_q;

endmodule
